// File: rtl/rv32i_mem_top.sv
// RV32I memory stage: load/store decode, data-RAM strobes, IO request/ack FSM and the MEM/WB register.
// Define RV32I_MEM_MISALIGN_CHK_EN to suppress and flag misaligned half/word accesses.
//
// state   | meaning
// IDLE    | no IO access outstanding
// IO_WAIT | IO request issued, holding it until io_ack
module rv32i_mem_top #(
    parameter logic [31:0] IO_BASE = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] iw_in,
    input  logic [31:0] alu_in,
    input  logic [31:0] rs2_in,
    input  logic [4:0]  wb_reg_in,
    input  logic        wb_en_in,
    output logic        stall_out,
    output logic [31:0] memif_addr,
    output logic        memif_we,
    output logic [3:0]  memif_be,
    output logic [31:0] memif_wdata,
    output logic        io_req,
    output logic        io_we,
    output logic [31:0] io_addr,
    output logic [31:0] io_wdata,
    output logic [3:0]  io_be,
    input  logic        io_ack,
    input  logic [31:0] io_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] iw_out,
    output logic [31:0] alu_out,
    output logic [31:0] io_rdata_out,
    output logic [4:0]  wb_reg_out,
    output logic        wb_en_out,
    output logic [1:0]  src_sel_out,
    output logic [4:0]  ld_ctrl_out,
    output logic        misalign_out,
    output logic        df_mem_enable,
    output logic [4:0]  df_mem_reg,
    output logic [31:0] df_mem_data
);

    typedef enum logic {IDLE, IO_WAIT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, iw_q, iw_d, alu_q, alu_d, io_rdata_q, io_rdata_d;
    logic [4:0]  wb_reg_q, wb_reg_d, ld_ctrl_q, ld_ctrl_d;
    logic        wb_en_q, wb_en_d, misalign_q, misalign_d;
    logic [1:0]  src_sel_q, src_sel_d;

    logic [2:0]  funct3;
    logic [1:0]  a_lo;
    logic        is_load, is_store, is_mem, is_io;
    logic        sz_byte, sz_half, sz_word;
    logic        misaligned, io_access, io_req_raw;
    logic [3:0]  be;
    logic [31:0] wdata;

    always_comb begin
        funct3   = iw_in[14:12];
        a_lo     = alu_in[1:0];
        is_load  = (iw_in[6:0] == 7'b0000011);
        is_store = (iw_in[6:0] == 7'b0100011);
        is_mem   = is_load | is_store;
        is_io    = (alu_in >= IO_BASE);
        sz_byte  = (funct3 == 3'd0) | (funct3 == 3'd4);
        sz_half  = (funct3 == 3'd1) | (funct3 == 3'd5);
        sz_word  = (funct3 == 3'd2);

        be    = 4'b0000;
        wdata = rs2_in;
        if (sz_byte) begin
            be    = 4'b0001 << a_lo;
            wdata = {4{rs2_in[7:0]}};
        end else if (sz_half) begin
            be    = 4'b0011 << {a_lo[1], 1'b0};
            wdata = {2{rs2_in[15:0]}};
        end else if (sz_word) begin
            be = 4'b1111;
        end

`ifdef RV32I_MEM_MISALIGN_CHK_EN
        misaligned = (sz_half & a_lo[0]) | (sz_word & (|a_lo));
`else
        misaligned = 1'b0;
`endif
        io_access = valid_in & is_mem & is_io & ~misaligned;
    end

    // Upstream holds its inputs during a stall, so io_* stay stable in IO_WAIT.
    always_comb begin
        state_d    = state_q;
        io_req_raw = 1'b0;
        case (state_q)
            IDLE: begin
                if (io_access) begin
                    io_req_raw = 1'b1;
                    if (!io_ack) state_d = IO_WAIT;
                end
            end
            IO_WAIT: begin
                io_req_raw = 1'b1;
                if (io_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Gating with reset makes an abort visible immediately, not at the next edge.
    always_comb begin
        io_req      = io_req_raw & reset;
        stall_out   = io_req & ~io_ack;
        io_we       = is_store;
        io_addr     = alu_in;
        io_wdata    = wdata;
        io_be       = be;
        memif_addr  = {alu_in[31:2], 2'b00};
        memif_we    = valid_in & is_store & ~is_io & ~misaligned & reset;
        memif_be    = be;
        memif_wdata = wdata;
    end

    always_comb begin
        pc_d       = pc_q;
        iw_d       = iw_q;
        alu_d      = alu_q;
        wb_reg_d   = wb_reg_q;
        ld_ctrl_d  = ld_ctrl_q;
        src_sel_d  = src_sel_q;
        wb_en_d    = 1'b0;
        misalign_d = 1'b0;
        if (!stall_out) begin
            pc_d       = pc_in;
            iw_d       = iw_in;
            alu_d      = alu_in;
            wb_reg_d   = wb_reg_in;
            ld_ctrl_d  = {funct3, a_lo};
            wb_en_d    = valid_in & wb_en_in & ~misaligned & ~is_store;
            misalign_d = valid_in & is_mem & misaligned;
            if (valid_in && is_load) src_sel_d = is_io ? 2'd1 : 2'd0;
            else                     src_sel_d = 2'd2;
        end
        io_rdata_d = (io_req_raw && io_ack) ? io_rdata : io_rdata_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            iw_q       <= '0;
            alu_q      <= '0;
            io_rdata_q <= '0;
            wb_reg_q   <= '0;
            wb_en_q    <= 1'b0;
            src_sel_q  <= 2'd2;
            ld_ctrl_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            iw_q       <= iw_d;
            alu_q      <= alu_d;
            io_rdata_q <= io_rdata_d;
            wb_reg_q   <= wb_reg_d;
            wb_en_q    <= wb_en_d;
            src_sel_q  <= src_sel_d;
            ld_ctrl_q  <= ld_ctrl_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc_out        = pc_q;
    assign iw_out        = iw_q;
    assign alu_out       = alu_q;
    assign io_rdata_out  = io_rdata_q;
    assign wb_reg_out    = wb_reg_q;
    assign wb_en_out     = wb_en_q;
    assign src_sel_out   = src_sel_q;
    assign ld_ctrl_out   = ld_ctrl_q;
    assign misalign_out  = misalign_q;
    assign df_mem_enable = wb_en_q;
    assign df_mem_reg    = wb_reg_q;
    assign df_mem_data   = alu_q;

endmodule

// File: tb/tb_rv32i_mem_top.sv
// Bench for rv32i_mem_top: directed cases then random load/store/ALU traffic against a lane-level model.
module tb_rv32i_mem_top;

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_ALU = 7'b0110011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, valid_in, wb_en_in, io_ack;
    logic [31:0] pc_in, iw_in, alu_in, rs2_in, io_rdata;
    logic [4:0]  wb_reg_in;
    logic        stall_out, memif_we, io_req, io_we, wb_en_out, misalign_out, df_mem_enable;
    logic [31:0] memif_addr, memif_wdata, io_addr, io_wdata, pc_out, iw_out, alu_out;
    logic [31:0] io_rdata_out, df_mem_data;
    logic [3:0]  memif_be, io_be;
    logic [4:0]  wb_reg_out, ld_ctrl_out, df_mem_reg;
    logic [1:0]  src_sel_out;

    rv32i_mem_top dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .pc_in(pc_in), .iw_in(iw_in),
        .alu_in(alu_in), .rs2_in(rs2_in), .wb_reg_in(wb_reg_in), .wb_en_in(wb_en_in),
        .stall_out(stall_out), .memif_addr(memif_addr), .memif_we(memif_we),
        .memif_be(memif_be), .memif_wdata(memif_wdata), .io_req(io_req), .io_we(io_we),
        .io_addr(io_addr), .io_wdata(io_wdata), .io_be(io_be), .io_ack(io_ack),
        .io_rdata(io_rdata), .pc_out(pc_out), .iw_out(iw_out), .alu_out(alu_out),
        .io_rdata_out(io_rdata_out), .wb_reg_out(wb_reg_out), .wb_en_out(wb_en_out),
        .src_sel_out(src_sel_out), .ld_ctrl_out(ld_ctrl_out), .misalign_out(misalign_out),
        .df_mem_enable(df_mem_enable), .df_mem_reg(df_mem_reg), .df_mem_data(df_mem_data)
    );

    int n_chk = 0;
    int n_err = 0;

    // Model of the registered outputs.
    logic [31:0] m_pc, m_iw, m_alu, m_rdata;
    logic [4:0]  m_wbreg, m_ldc;
    logic        m_wben, m_mis;
    logic [1:0]  m_src;

    // Responder and snapshot state.
    int          cur_lat, wait_cnt;
    bit          rd_fixed_en;
    logic [31:0] rd_fixed;
    logic        s_we;
    logic [3:0]  s_be;
    logic [31:0] s_wdata, s_addr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit model_mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef RV32I_MEM_MISALIGN_CHK_EN
        return (int'(a[1:0]) % nbytes(f3)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int n = nbytes(f3);
        int base = int'(a[1:0]) - (int'(a[1:0]) % n);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (i >= base) && (i < base + n);
        return r;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        int n = nbytes(f3);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mk_iw(input logic [6:0] op, input logic [2:0] f3);
        logic [31:0] w = $urandom;
        w[14:12] = f3;
        w[6:0]   = op;
        return w;
    endfunction

    task automatic model_reset();
        m_pc = '0; m_iw = '0; m_alu = '0; m_rdata = '0; m_wbreg = '0;
        m_ldc = '0; m_wben = 1'b0; m_mis = 1'b0; m_src = 2'd2;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".pc_out"}, pc_out, m_pc);
        chk({tag, ".iw_out"}, iw_out, m_iw);
        chk({tag, ".alu_out"}, alu_out, m_alu);
        chk({tag, ".wb_reg_out"}, wb_reg_out, m_wbreg);
        chk({tag, ".wb_en_out"}, wb_en_out, m_wben);
        chk({tag, ".src_sel_out"}, src_sel_out, m_src);
        chk({tag, ".ld_ctrl_out"}, ld_ctrl_out, m_ldc);
        chk({tag, ".misalign_out"}, misalign_out, m_mis);
        chk({tag, ".io_rdata_out"}, io_rdata_out, m_rdata);
        chk({tag, ".df_mem_enable"}, df_mem_enable, m_wben);
        chk({tag, ".df_mem_reg"}, df_mem_reg, m_wbreg);
        chk({tag, ".df_mem_data"}, df_mem_data, m_alu);
    endtask

    // One clock: called just after a rising edge with the inputs already driven.
    task automatic tick(output bit st, output bit rq);
        logic [2:0] f3 = iw_in[14:12];
        bit ld  = valid_in && (iw_in[6:0] == OP_LD);
        bit sto = valid_in && (iw_in[6:0] == OP_ST);
        bit io  = (alu_in >= 32'hFFFF_0000);
        bit mis = (ld || sto) && model_mis(f3, alu_in);
        bit req = reset && (ld || sto) && io && !mis;
        bit we  = reset && sto && !io && !mis;
        if (req) begin
            io_ack = (wait_cnt == cur_lat);
            io_rdata = rd_fixed_en ? rd_fixed : $urandom;
        end else begin
            io_ack = ($urandom_range(0, 3) == 0);
            io_rdata = $urandom;
        end
        st = req && !io_ack;
        rq = req;

        @(negedge clk);
        chk("stall_out", stall_out, st);
        chk("io_req", io_req, req);
        chk("memif_we", memif_we, we);
        chk("memif_addr", memif_addr, alu_in & 32'hFFFF_FFFC);
        if (ld || sto) begin
            chk("memif_be", memif_be, model_be(f3, alu_in));
            if (sto) chk("memif_wdata", memif_wdata, model_wdata(f3, rs2_in));
        end
        if (req) begin
            chk("io_addr", io_addr, alu_in);
            chk("io_we", io_we, sto);
            chk("io_be", io_be, model_be(f3, alu_in));
            if (sto) chk("io_wdata", io_wdata, model_wdata(f3, rs2_in));
        end
        s_we = memif_we; s_be = memif_be; s_wdata = memif_wdata; s_addr = memif_addr;

        @(posedge clk);
        #1;
        if (req && io_ack) m_rdata = io_rdata;
        if (st) begin
            m_wben = 1'b0;
            m_mis  = 1'b0;
        end else begin
            m_pc    = pc_in;
            m_iw    = iw_in;
            m_alu   = alu_in;
            m_wbreg = wb_reg_in;
            m_ldc   = {f3, alu_in[1:0]};
            m_wben  = valid_in && wb_en_in && !mis && !sto;
            m_mis   = mis;
            m_src   = ld ? (io ? 2'd1 : 2'd0) : 2'd2;
        end
        check_regs("reg");
        wait_cnt = st ? wait_cnt + 1 : 0;
        io_ack = 1'b0;
    endtask

    task automatic issue(input logic v, input logic [31:0] pc, input logic [31:0] iw,
                         input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] wr,
                         input logic we, input int lat, output int ns, output int nr);
        bit st, rq, done;
        valid_in = v; pc_in = pc; iw_in = iw; alu_in = alu; rs2_in = rs2;
        wb_reg_in = wr; wb_en_in = we;
        cur_lat = lat; wait_cnt = 0; ns = 0; nr = 0; done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick(st, rq);
            ns += int'(st);
            nr += int'(rq);
            if (!st) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_chk++;
            n_err++;
            $display("FAIL stall_bound: stall_out still high after 20 cycles");
        end
    endtask

    task automatic bubble();
        int ns, nr;
        issue(1'b0, $urandom, mk_iw(OP_ALU, 3'd0), $urandom & 32'h0FFF_FFFF, $urandom, 5'd0, 1'b0, 0, ns, nr);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ns, nr;
        bit st, rq;
        reset = 1'b0; valid_in = 1'b0; pc_in = '0; iw_in = '0; alu_in = '0; rs2_in = '0;
        wb_reg_in = '0; wb_en_in = 1'b0; io_ack = 1'b0; io_rdata = '0;
        rd_fixed_en = 1'b0; rd_fixed = '0; cur_lat = 0; wait_cnt = 0;
        model_reset();
        #12;
        chk("rst.src_sel_out", src_sel_out, 32'd2);
        chk("rst.wb_en_out", wb_en_out, 32'd0);
        chk("rst.pc_out", pc_out, 32'd0);
        chk("rst.io_req", io_req, 32'd0);
        check_regs("rst");
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        // SW DEADBEEF to 0x100
        issue(1'b1, 32'h1000, mk_iw(OP_ST, 3'd2), 32'h100, 32'hDEADBEEF, 5'd3, 1'b1, 0, ns, nr);
        chk("sw.memif_we", s_we, 32'd1);
        chk("sw.memif_be", s_be, 32'hF);
        chk("sw.memif_wdata", s_wdata, 32'hDEADBEEF);
        chk("sw.memif_addr", s_addr, 32'h100);
        chk("sw.wb_en_out", wb_en_out, 32'd0);

        issue(1'b1, 32'h1004, mk_iw(OP_ST, 3'd0), 32'h203, 32'h123456A5, 5'd0, 1'b0, 0, ns, nr);
        chk("sb.memif_be", s_be, 32'h8);
        chk("sb.memif_wdata", s_wdata, 32'hA5A5A5A5);
        issue(1'b1, 32'h1008, mk_iw(OP_ST, 3'd1), 32'h202, 32'h0000BEEF, 5'd0, 1'b0, 0, ns, nr);
        chk("sh.memif_be", s_be, 32'hC);
        chk("sh.memif_wdata", s_wdata, 32'hBEEFBEEF);

        // LW from IO, ack after 3 waiting cycles
        rd_fixed_en = 1'b1; rd_fixed = 32'h1234_5678;
        issue(1'b1, 32'h100C, mk_iw(OP_LD, 3'd2), 32'hFFFF_0010, 32'h0, 5'd7, 1'b1, 3, ns, nr);
        chk("lw_io.stall_cycles", ns, 32'd3);
        chk("lw_io.io_rdata_out", io_rdata_out, 32'h1234_5678);
        chk("lw_io.src_sel_out", src_sel_out, 32'd1);
        chk("lw_io.wb_en_out", wb_en_out, 32'd1);
        rd_fixed_en = 1'b0;
        bubble();
        chk("lw_io.wb_en_after", wb_en_out, 32'd0);

        // IO write acknowledged in the same cycle
        issue(1'b1, 32'h1010, mk_iw(OP_ST, 3'd2), 32'hFFFF_0020, 32'hCAFEF00D, 5'd0, 1'b0, 0, ns, nr);
        chk("sw_io.stall_cycles", ns, 32'd0);
        chk("sw_io.req_cycles", nr, 32'd1);

        // Misaligned SW
        issue(1'b1, 32'h1014, mk_iw(OP_ST, 3'd2), 32'h102, 32'h11223344, 5'd0, 1'b1, 0, ns, nr);
`ifdef RV32I_MEM_MISALIGN_CHK_EN
        chk("mis.memif_we", s_we, 32'd0);
        chk("mis.misalign_out", misalign_out, 32'd1);
`else
        chk("mis.memif_we", s_we, 32'd1);
        chk("mis.misalign_out", misalign_out, 32'd0);
`endif
        chk("mis.wb_en_out", wb_en_out, 32'd0);
        bubble();
        chk("mis.pulse_end", misalign_out, 32'd0);

        // Reset while waiting on an IO load
        valid_in = 1'b1; pc_in = 32'h2000; iw_in = mk_iw(OP_LD, 3'd2); alu_in = 32'hFFFF_0040;
        wb_reg_in = 5'd9; wb_en_in = 1'b1; cur_lat = 5; wait_cnt = 0;
        tick(st, rq);
        chk("abort.stalled", st, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("abort.io_req", io_req, 32'd0);
        chk("abort.stall_out", stall_out, 32'd0);
        chk("abort.src_sel_out", src_sel_out, 32'd2);
        model_reset();
        check_regs("abort");
        @(negedge clk); valid_in = 1'b0;
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        issue(1'b1, 32'h2004, mk_iw(OP_ALU, 3'd0), 32'h55AA_1234, 32'h0, 5'd11, 1'b1, 0, ns, nr);
        chk("add.src_sel_out", src_sel_out, 32'd2);
        chk("add.df_mem_data", df_mem_data, 32'h55AA_1234);
        chk("add.df_mem_enable", df_mem_enable, 32'd1);
        chk("add.df_mem_reg", df_mem_reg, 32'd11);

        // Random traffic
        for (int t = 0; t < 400; t++) begin
            int kind = $urandom_range(0, 9);
            int asel = $urandom_range(0, 7);
            logic [31:0] a = $urandom;
            logic [2:0] f3;
            logic [6:0] op;
            logic v = 1'b1;
            if (asel < 2)       a = {16'hFFFF, a[15:0]};
            else if (asel == 2) a = {30'h3FFF_C000, a[1:0]};
            else if (asel == 3) a = {30'h3FFF_BFFF, a[1:0]};
            else if (a >= 32'hFFFF_0000) a[16] = 1'b0;
            if (kind < 4) begin
                op = OP_LD;
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
                endcase
            end else if (kind < 7) begin
                op = OP_ST;
                f3 = 3'($urandom_range(0, 2));
            end else begin
                op = ($urandom_range(0, 1) == 0) ? OP_ALU : 7'b0010011;
                f3 = 3'($urandom);
                v = (kind != 9);
            end
            issue(v, $urandom, mk_iw(op, f3), a, $urandom, 5'($urandom), 1'($urandom),
                  $urandom_range(0, 3), ns, nr);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/rv32i_mem_top.md
# rv32i_mem_top

Memory-access pipeline stage between exTop and wbTop. Decodes load/store instructions and drives the synchronous data RAM with byte enables and lane-aligned write data. Runs a request/acknowledge FSM for the variable-latency IO space and stalls upstream while an IO access is pending. Registers the pipeline payload plus a source selector for wbTop, and exports forwarding data for the memory stage.

## Interface
- IO_BASE, 32'hFFFF_0000, addresses ≥ IO_BASE (unsigned) are IO space; all others are RAM.
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- valid_in  in  1  exTop payload valid
- pc_in, iw_in, alu_in  in  32 each  PC, instruction word, ALU result/effective address
- rs2_in  in  32  store data
- wb_reg_in  in  5  destination register
- wb_en_in  in  1  writeback requested
- stall_out  out  1  hold upstream payload stable
- memif_addr  out  32  RAM word address, {alu_in[31:2],2'b00}
- memif_we  out  1  RAM write strobe
- memif_be  out  4  RAM byte enables
- memif_wdata  out  32  lane-aligned store data
- io_req, io_we  out  1 each  IO request / write
- io_addr, io_wdata  out  32 each  IO address / store data
- io_be  out  4  IO byte enables
- io_ack  in  1  IO access complete
- io_rdata  in  32  IO read data, valid with io_ack
- pc_out, iw_out, alu_out  out  32 each  registered payload to wbTop
- io_rdata_out  out  32  IO read data captured at io_ack
- wb_reg_out  out  5  registered destination
- wb_en_out  out  1  registered writeback enable
- src_sel_out  out  2  0 = RAM, 1 = IO, 2 = ALU
- ld_ctrl_out  out  5  {funct3, alu_in[1:0]} for load extension downstream
- misalign_out  out  1  registered misaligned-access flag
- df_mem_enable  out  1  forwarding: wb_en_out
- df_mem_reg  out  5  forwarding: wb_reg_out
- df_mem_data  out  32  forwarding: alu_out

## Operation
- Decode: opcode 7'b0000011 is a load; 7'b0100011 is a store. funct3 = iw_in[14:12]; size is byte for 0/4, half for 1/5, word for 2.
- Byte enables: byte = 4'b0001 << a[1:0]; half = 4'b0011 << {a[1],1'b0}; word = 4'b1111.
- Write data: byte is replicated to all four lanes; half is replicated to both halves; word is passed unchanged.
- RAM store: memif_we = valid_in & store & RAM space & ~misaligned. Asserted for exactly one cycle. RAM loads need no strobe.
- src_sel: load from RAM → 0; load from IO → 1; anything else → 2.
- FSM states IDLE and IO_WAIT.
  - IDLE: on a valid IO load or store, assert io_req.
    - io_ack in the same cycle: the access completes and no stall occurs.
    - No io_ack: go to IO_WAIT.
  - IO_WAIT: hold io_req, io_addr, io_be, io_we and io_wdata stable; assert stall_out; on io_ack go to IDLE.
- stall_out = io_req & ~io_ack.
- Pipeline register: on each edge with stall_out = 0, load the payload. wb_en_out = valid_in & wb_en_in & ~misaligned; stores force it to 0.
- While stall_out = 1, the register loads a bubble: wb_en_out = 0, misalign_out = 0, other fields hold.
- io_rdata_out is loaded on io_ack; otherwise it holds.

## Timing
- Reset (asynchronous assert, synchronous release): FSM = IDLE; all registered outputs = 0; src_sel_out = 2.
- Reset asserted during IO_WAIT aborts the access; io_req drops immediately.
- memif_* and io_* are combinational from the inputs in the current cycle. RAM read data arrives one cycle later, aligned with the instruction reaching wbTop.
- Payload latency: 1 cycle. IO access latency: 1 + N cycles, where N is the number of cycles waiting for io_ack; the stall lasts N cycles.
- Upstream must hold all inputs stable while stall_out = 1.
- io_ack outside a request is ignored.

## Configuration
- RV32I_MEM_MISALIGN_CHK_EN defined:
  - misaligned = (half & a[0]) | (word & |a[1:0]).
  - A misaligned access suppresses memif_we and io_req, and forces wb_en_out = 0.
  - misalign_out pulses high for one cycle.
- Undefined: misaligned is tied to 0; address low bits select lanes only; misalign_out is held at 0.

## Test plan
- SW rs2 = 32'hDEADBEEF to address 0x100 → memif_we = 1, memif_be = 4'hF, memif_wdata = DEADBEEF, memif_addr = 0x100; wb_en_out = 0 next cycle.
- SB 0xA5 to 0x203 → memif_be = 4'b1000, memif_wdata = A5A5A5A5; SH to 0x202 → memif_be = 4'b1100.
- LW from 0xFFFF_0010 with io_ack after 3 cycles → stall_out high for 3 cycles, then 0; io_rdata_out = io_rdata; src_sel_out = 1; wb_en_out = 1 for exactly one cycle.
- IO write with io_ack in the same cycle → no stall; io_req high for exactly 1 cycle.
- SW to 0x102 with macro defined → memif_we = 0, misalign_out = 1, wb_en_out = 0. Without the macro → memif_we = 1, misalign_out = 0.
- reset low in IO_WAIT → io_req = 0, stall_out = 0, all outputs 0 and src_sel_out = 2 immediately. After release, a following ADD passes with src_sel_out = 2 and df_mem_data = alu_in.
